mpu_region_table: RTL and testbench
===================================

Name: mpu_region_table

Overview:
- Responder end of the MPU programming interface. Accepts `mpu_prog_*` region writes, stores up to NREG regions and enforces a sticky LOCK.
- Performs registered permission checks for the instruction-fetch port and the data port of the HarvOS core.
- Harvard-aware: I-space regions match only fetches; D-space regions match only loads and stores.
- Default-deny: an access that matches no valid region faults.

Parameters:
- NREG, 8, number of region entries; legal range 2..16.
- IDXW, 3, width of region index ports; must equal ceil(log2(NREG)).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- mpu_prog_en  in  1  write strobe; one region is written per cycle
- mpu_prog_idx  in  IDXW  target region index
- mpu_prog_base  in  32  region base, inclusive
- mpu_prog_limit  in  32  region limit, inclusive
- mpu_prog_perm  in  3  {X,W,R}
- mpu_prog_user_ok  in  1  user mode permitted
- mpu_prog_is_ispace  in  1  1 = I-space region, 0 = D-space region
- lock_set  in  1  pulse from smpuctl.LOCK write; sets sticky lock
- locked  out  1  lock status
- prog_err  out  1  one-cycle pulse: the previous cycle's write was rejected
- if_req  in  1  fetch check request
- if_addr  in  32  fetch address
- if_user  in  1  requester in user mode
- if_rsp_valid  out  1  fetch result valid
- if_fault  out  1  fetch denied
- if_cause  out  2  0 ok, 1 no match, 2 permission, 3 user
- if_region  out  IDXW  matched region index; 0 when no match
- d_req  in  1  data check request
- d_addr  in  32  data address
- d_we  in  1  1 = store, 0 = load
- d_user  in  1  requester in user mode
- d_rsp_valid, d_fault, d_cause, d_region  out  1/1/2/IDXW  same meanings as the fetch port

Behaviour:

Reset:
- All entries are invalid and all region fields are zero.
- locked=0, prog_err=0.
- All *_rsp_valid, *_fault, *_cause and *_region outputs are 0.

Programming:
- Evaluated on a clock edge where mpu_prog_en=1.
- The write is rejected if any of the following holds: locked=1, lock_set=1 in the same cycle (lock wins), mpu_prog_idx >= NREG, or perm has both X and W set (W^X).
- Rejected write: the entry is unchanged and prog_err=1 in the next cycle.
- Accepted write: the entry fields are replaced, valid=1, and prog_err=0 next cycle.
- Writes to the same index on consecutive cycles are legal; the last write wins.

Lock:
- lock_set=1 sets locked on the next edge.
- locked is cleared only by rst. There is no unlock path.

Match:
- An entry matches when it is valid, base <= addr <= limit (unsigned 32-bit), and its is_ispace equals the port type (fetch = 1, data = 0).
- An entry with base > limit never matches.
- When several entries match, the lowest index wins.

Check, fetch port (evaluated on the winning entry only; first failing rule sets the cause):
- No match: cause 1.
- X=0: cause 2.
- if_user=1 and user_ok=0: cause 3.
- Otherwise: cause 0.

Check, data port (same rule order):
- No match: cause 1.
- Load with R=0, or store with W=0: cause 2.
- d_user=1 and user_ok=0: cause 3.
- Otherwise: cause 0.
- fault = (cause != 0).

Latency and ordering:
- Latency is exactly 1 cycle. A request at edge N produces rsp_valid=1 and registered fault/cause/region after edge N, held for one cycle.
- Without a request, rsp_valid=0 and the other response outputs hold their previous values.
- The two ports are fully independent and may issue every cycle; there is no backpressure.
- A check in the same cycle as a write uses the table contents before that write.

Reset mid-operation:
- In-flight responses are discarded.
- All outputs return to their reset values asynchronously.

Test Plan:
1. Program idx0 base 0x0 limit 0xFFFF perm 101 user_ok 1 is_ispace 1. Fetch 0x0000_0100 with if_user=1 -> next cycle: if_rsp_valid=1, if_fault=0, if_cause=0, if_region=0.
2. With the table from scenario 1, load d_addr 0x0000_0100 -> d_fault=1, d_cause=1 (I-space region is invisible to the data port). Fetch 0x2000_0000 -> if_cause=1.
3. Program idx2 0x1000_0000..0x1000_FFFF perm 011 user_ok 0 is_ispace 0. Store 0x1000_0010 with d_user=1 -> d_cause=3. Same store with d_user=0 -> d_fault=0, d_region=2.
4. Program idx1 perm 011 D-space 0x2000_0000..0x2001_FFFF and idx3 perm 001 over the same range. Store 0x2000_0004 -> d_fault=0, d_region=1. Invalidate-free retest after a reset with only idx3 programmed -> d_cause=2.
5. Program with perm 111 -> prog_err=1 for one cycle, entry stays invalid, a later access in that range gives cause 1. Program with mpu_prog_idx=NREG (when NREG<8) -> prog_err=1.
6. Pulse lock_set, then mpu_prog_en to idx1 -> locked=1, prog_err=1, old entry intact. lock_set and mpu_prog_en in the same cycle -> rejected. Assert rst -> locked=0, all entries invalid, every access gives cause 1.

Source files
------------

// File: rtl/mpu_region_table.sv
// MPU region table: programmable region store with sticky lock and registered
// Harvard-aware permission checks for the fetch and data ports (default-deny).
module mpu_region_table #(
    parameter int NREG = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mpu_prog_en,
    input  logic [IDXW-1:0] mpu_prog_idx,
    input  logic [31:0]     mpu_prog_base,
    input  logic [31:0]     mpu_prog_limit,
    input  logic [2:0]      mpu_prog_perm,
    input  logic            mpu_prog_user_ok,
    input  logic            mpu_prog_is_ispace,
    input  logic            lock_set,
    output logic            locked,
    output logic            prog_err,
    input  logic            if_req,
    input  logic [31:0]     if_addr,
    input  logic            if_user,
    output logic            if_rsp_valid,
    output logic            if_fault,
    output logic [1:0]      if_cause,
    output logic [IDXW-1:0] if_region,
    input  logic            d_req,
    input  logic [31:0]     d_addr,
    input  logic            d_we,
    input  logic            d_user,
    output logic            d_rsp_valid,
    output logic            d_fault,
    output logic [1:0]      d_cause,
    output logic [IDXW-1:0] d_region
);

    localparam logic [31:0] NREG_W = 32'(NREG);

    localparam logic [1:0] CAUSE_OK    = 2'd0;
    localparam logic [1:0] CAUSE_NONE  = 2'd1;
    localparam logic [1:0] CAUSE_PERM  = 2'd2;
    localparam logic [1:0] CAUSE_USER  = 2'd3;

    logic [NREG-1:0] valid_r;
    logic [NREG-1:0] user_ok_r;
    logic [NREG-1:0] ispace_r;
    logic [31:0]     base_r  [NREG];
    logic [31:0]     limit_r [NREG];
    logic [2:0]      perm_r  [NREG];

    logic            locked_r;
    logic            prog_err_r;
    logic            prog_reject_s;
    logic            prog_accept_s;

    logic [NREG-1:0] if_match_s;
    logic [NREG-1:0] d_match_s;
    logic            if_hit_s;
    logic            d_hit_s;
    logic [IDXW-1:0] if_idx_s;
    logic [IDXW-1:0] d_idx_s;
    logic [1:0]      if_cause_s;
    logic [1:0]      d_cause_s;

    logic            if_rsp_valid_r;
    logic [1:0]      if_cause_r;
    logic [IDXW-1:0] if_region_r;
    logic            d_rsp_valid_r;
    logic [1:0]      d_cause_r;
    logic [IDXW-1:0] d_region_r;

    // Lowest set bit wins: returns {hit, index}, index 0 when nothing is set.
    function automatic logic [IDXW:0] pick_lowest(input logic [NREG-1:0] m);
        logic [IDXW:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = {1'b1, IDXW'(i)};
            end
        end
        return r;
    endfunction

    // A pending lock in the same cycle already blocks the write.
    always_comb begin
        prog_reject_s = locked_r | lock_set
                      | ({{(32-IDXW){1'b0}}, mpu_prog_idx} >= NREG_W)
                      | (mpu_prog_perm[2] & mpu_prog_perm[1]);
        prog_accept_s = mpu_prog_en & ~prog_reject_s;
    end

    // Region table storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= '0;
            user_ok_r <= '0;
            ispace_r  <= '0;
            for (int i = 0; i < NREG; i++) begin
                base_r[i]  <= 32'h0;
                limit_r[i] <= 32'h0;
                perm_r[i]  <= 3'b000;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (prog_accept_s && (mpu_prog_idx == IDXW'(i))) begin
                    valid_r[i]   <= 1'b1;
                    user_ok_r[i] <= mpu_prog_user_ok;
                    ispace_r[i]  <= mpu_prog_is_ispace;
                    base_r[i]    <= mpu_prog_base;
                    limit_r[i]   <= mpu_prog_limit;
                    perm_r[i]    <= mpu_prog_perm;
                end
            end
        end
    end

    // Sticky lock and write-rejection pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_r   <= 1'b0;
            prog_err_r <= 1'b0;
        end else begin
            locked_r   <= locked_r | lock_set;
            prog_err_r <= mpu_prog_en & prog_reject_s;
        end
    end

    // Per-entry address match; base > limit can never satisfy both bounds.
    always_comb begin
        if_match_s = '0;
        d_match_s  = '0;
        for (int i = 0; i < NREG; i++) begin
            if_match_s[i] = valid_r[i] & ispace_r[i]
                          & (base_r[i] <= if_addr) & (if_addr <= limit_r[i]);
            d_match_s[i]  = valid_r[i] & ~ispace_r[i]
                          & (base_r[i] <= d_addr) & (d_addr <= limit_r[i]);
        end
        {if_hit_s, if_idx_s} = pick_lowest(if_match_s);
        {d_hit_s, d_idx_s}   = pick_lowest(d_match_s);
    end

    // Fetch permission check on the winning entry.
    always_comb begin
        if_cause_s = CAUSE_OK;
        if (!if_hit_s) begin
            if_cause_s = CAUSE_NONE;
        end else if (!perm_r[if_idx_s][2]) begin
            if_cause_s = CAUSE_PERM;
        end else if (if_user && !user_ok_r[if_idx_s]) begin
            if_cause_s = CAUSE_USER;
        end else begin
            if_cause_s = CAUSE_OK;
        end
    end

    // Data permission check: stores need W, loads need R.
    always_comb begin
        d_cause_s = CAUSE_OK;
        if (!d_hit_s) begin
            d_cause_s = CAUSE_NONE;
        end else if (d_we ? !perm_r[d_idx_s][1] : !perm_r[d_idx_s][0]) begin
            d_cause_s = CAUSE_PERM;
        end else if (d_user && !user_ok_r[d_idx_s]) begin
            d_cause_s = CAUSE_USER;
        end else begin
            d_cause_s = CAUSE_OK;
        end
    end

    // Response registers; result fields hold when no request is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rsp_valid_r <= 1'b0;
            if_cause_r     <= 2'd0;
            if_region_r    <= '0;
            d_rsp_valid_r  <= 1'b0;
            d_cause_r      <= 2'd0;
            d_region_r     <= '0;
        end else begin
            if_rsp_valid_r <= if_req;
            d_rsp_valid_r  <= d_req;
            if (if_req) begin
                if_cause_r  <= if_cause_s;
                if_region_r <= if_idx_s;
            end
            if (d_req) begin
                d_cause_r  <= d_cause_s;
                d_region_r <= d_idx_s;
            end
        end
    end

    assign locked       = locked_r;
    assign prog_err     = prog_err_r;
    assign if_rsp_valid = if_rsp_valid_r;
    assign if_fault     = (if_cause_r != CAUSE_OK);
    assign if_cause     = if_cause_r;
    assign if_region    = if_region_r;
    assign d_rsp_valid  = d_rsp_valid_r;
    assign d_fault      = (d_cause_r != CAUSE_OK);
    assign d_cause      = d_cause_r;
    assign d_region     = d_region_r;

endmodule

// File: tb/tb_mpu_region_table.sv
// Scoreboard bench for mpu_region_table: directed stimulus pushes expected
// responses, a negedge monitor pops and compares whenever the DUT responds.
module tb_mpu_region_table;

    localparam int NREG = 6;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            mpu_prog_en;
    logic [IDXW-1:0] mpu_prog_idx;
    logic [31:0]     mpu_prog_base;
    logic [31:0]     mpu_prog_limit;
    logic [2:0]      mpu_prog_perm;
    logic            mpu_prog_user_ok;
    logic            mpu_prog_is_ispace;
    logic            lock_set;
    logic            locked;
    logic            prog_err;
    logic            if_req;
    logic [31:0]     if_addr;
    logic            if_user;
    logic            if_rsp_valid;
    logic            if_fault;
    logic [1:0]      if_cause;
    logic [IDXW-1:0] if_region;
    logic            d_req;
    logic [31:0]     d_addr;
    logic            d_we;
    logic            d_user;
    logic            d_rsp_valid;
    logic            d_fault;
    logic [1:0]      d_cause;
    logic [IDXW-1:0] d_region;

    mpu_region_table #(.NREG(NREG), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .mpu_prog_en(mpu_prog_en), .mpu_prog_idx(mpu_prog_idx),
        .mpu_prog_base(mpu_prog_base), .mpu_prog_limit(mpu_prog_limit),
        .mpu_prog_perm(mpu_prog_perm), .mpu_prog_user_ok(mpu_prog_user_ok),
        .mpu_prog_is_ispace(mpu_prog_is_ispace), .lock_set(lock_set),
        .locked(locked), .prog_err(prog_err),
        .if_req(if_req), .if_addr(if_addr), .if_user(if_user),
        .if_rsp_valid(if_rsp_valid), .if_fault(if_fault),
        .if_cause(if_cause), .if_region(if_region),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_user(d_user),
        .d_rsp_valid(d_rsp_valid), .d_fault(d_fault),
        .d_cause(d_cause), .d_region(d_region)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      cause;
        logic [IDXW-1:0] region;
    } rsp_t;

    rsp_t if_q[$];
    rsp_t d_q[$];
    logic prog_q[$];
    int   checks = 0;
    int   passed = 0;

    logic if_iss, d_iss, prog_iss;
    rsp_t mon_e;
    logic mon_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Which requests the DUT accepted at the last edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if_iss   <= 1'b0;
            d_iss    <= 1'b0;
            prog_iss <= 1'b0;
        end else begin
            if_iss   <= if_req;
            d_iss    <= d_req;
            prog_iss <= mpu_prog_en;
        end
    end

    // Monitor: compare every response against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            chk("if_rsp_valid", 32'(if_rsp_valid), 32'(if_iss));
            if (if_rsp_valid) begin
                if (if_q.size() == 0) begin
                    checks++;
                    $display("FAIL if_unexpected: got response, expected none");
                end else begin
                    mon_e = if_q.pop_front();
                    chk("if_cause", 32'(if_cause), 32'(mon_e.cause));
                    chk("if_fault", 32'(if_fault), 32'(mon_e.cause != 2'd0));
                    chk("if_region", 32'(if_region), 32'(mon_e.region));
                end
            end
            chk("d_rsp_valid", 32'(d_rsp_valid), 32'(d_iss));
            if (d_rsp_valid) begin
                if (d_q.size() == 0) begin
                    checks++;
                    $display("FAIL d_unexpected: got response, expected none");
                end else begin
                    mon_e = d_q.pop_front();
                    chk("d_cause", 32'(d_cause), 32'(mon_e.cause));
                    chk("d_fault", 32'(d_fault), 32'(mon_e.cause != 2'd0));
                    chk("d_region", 32'(d_region), 32'(mon_e.region));
                end
            end
            if (prog_iss) begin
                if (prog_q.size() == 0) begin
                    checks++;
                    $display("FAIL prog_unexpected: got write result, expected none");
                end else begin
                    mon_p = prog_q.pop_front();
                    chk("prog_err", 32'(prog_err), 32'(mon_p));
                end
            end else begin
                chk("prog_err_idle", 32'(prog_err), 32'd0);
            end
        end
    end

    task automatic clear_strobes();
        mpu_prog_en = 1'b0;
        lock_set    = 1'b0;
        if_req      = 1'b0;
        d_req       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic prog(input logic [IDXW-1:0] idx, input logic [31:0] b, input logic [31:0] l,
                        input logic [2:0] p, input logic uok, input logic isp, input logic exp_err);
        mpu_prog_en        = 1'b1;
        mpu_prog_idx       = idx;
        mpu_prog_base      = b;
        mpu_prog_limit     = l;
        mpu_prog_perm      = p;
        mpu_prog_user_ok   = uok;
        mpu_prog_is_ispace = isp;
        prog_q.push_back(exp_err);
    endtask

    task automatic fetch(input logic [31:0] a, input logic u,
                         input logic [1:0] c, input logic [IDXW-1:0] r);
        rsp_t e;
        if_req  = 1'b1;
        if_addr = a;
        if_user = u;
        e.cause  = c;
        e.region = r;
        if_q.push_back(e);
    endtask

    task automatic data(input logic [31:0] a, input logic we, input logic u,
                        input logic [1:0] c, input logic [IDXW-1:0] r);
        rsp_t e;
        d_req  = 1'b1;
        d_addr = a;
        d_we   = we;
        d_user = u;
        e.cause  = c;
        e.region = r;
        d_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_strobes();
        if_q.delete();
        d_q.delete();
        prog_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_prog_err", 32'(prog_err), 32'd0);
        chk("rst_if_valid", 32'(if_rsp_valid), 32'd0);
        chk("rst_if_fault", 32'(if_fault), 32'd0);
        chk("rst_if_cause", 32'(if_cause), 32'd0);
        chk("rst_if_region", 32'(if_region), 32'd0);
        chk("rst_d_valid", 32'(d_rsp_valid), 32'd0);
        chk("rst_d_fault", 32'(d_fault), 32'd0);
        chk("rst_d_cause", 32'(d_cause), 32'd0);
        chk("rst_d_region", 32'(d_region), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_strobes();
        mpu_prog_idx = '0; mpu_prog_base = 32'h0; mpu_prog_limit = 32'h0;
        mpu_prog_perm = 3'b000; mpu_prog_user_ok = 1'b0; mpu_prog_is_ispace = 1'b0;
        if_addr = 32'h0; if_user = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_user = 1'b0;
        do_reset();

        // I-space region visible to fetches only
        prog(3'd0, 32'h0000_0000, 32'h0000_FFFF, 3'b101, 1'b1, 1'b1, 1'b0); tick();
        fetch(32'h0000_0100, 1'b1, 2'd0, 3'd0); tick();
        data(32'h0000_0100, 1'b0, 1'b0, 2'd1, 3'd0);
        fetch(32'h2000_0000, 1'b0, 2'd1, 3'd0); tick();

        // D-space region with user restriction, plus result hold without request
        prog(3'd2, 32'h1000_0000, 32'h1000_FFFF, 3'b011, 1'b0, 1'b0, 1'b0); tick();
        data(32'h1000_0010, 1'b1, 1'b1, 2'd3, 3'd2); tick();
        tick();
        chk("d_cause_hold", 32'(d_cause), 32'd3);
        chk("d_region_hold", 32'(d_region), 32'd2);
        data(32'h1000_0010, 1'b1, 1'b0, 2'd0, 3'd2); tick();

        // Overlap: lowest index wins
        prog(3'd1, 32'h2000_0000, 32'h2001_FFFF, 3'b011, 1'b1, 1'b0, 1'b0); tick();
        prog(3'd3, 32'h2000_0000, 32'h2001_FFFF, 3'b001, 1'b1, 1'b0, 1'b0); tick();
        data(32'h2000_0004, 1'b1, 1'b0, 2'd0, 3'd1); tick();

        // Check in the write cycle sees the old table; then X=0 fetch
        prog(3'd4, 32'h3000_0000, 32'h3000_00FF, 3'b001, 1'b1, 1'b1, 1'b0);
        fetch(32'h3000_0010, 1'b0, 2'd1, 3'd0); tick();
        fetch(32'h3000_0010, 1'b0, 2'd2, 3'd4); tick();

        // base > limit never matches
        prog(3'd5, 32'h5000_0000, 32'h4000_0000, 3'b011, 1'b1, 1'b0, 1'b0); tick();
        data(32'h4800_0000, 1'b0, 1'b0, 2'd1, 3'd0); tick();
        data(32'h5000_0000, 1'b0, 1'b0, 2'd1, 3'd0); tick();

        // Back-to-back writes to one index: last wins
        prog(3'd5, 32'h6000_0000, 32'h6000_00FF, 3'b001, 1'b1, 1'b0, 1'b0); tick();
        prog(3'd5, 32'h6000_0000, 32'h6000_00FF, 3'b011, 1'b1, 1'b0, 1'b0); tick();
        data(32'h6000_0000, 1'b1, 1'b0, 2'd0, 3'd5); tick();

        // Reset with a fetch in flight; only idx3 afterwards
        if_req = 1'b1; if_addr = 32'h0000_0100; if_user = 1'b0;
        #1;
        do_reset();
        prog(3'd3, 32'h2000_0000, 32'h2001_FFFF, 3'b001, 1'b1, 1'b0, 1'b0); tick();
        data(32'h2000_0004, 1'b1, 1'b0, 2'd2, 3'd3);
        fetch(32'h2000_0004, 1'b0, 2'd1, 3'd0); tick();
        data(32'h2000_0004, 1'b0, 1'b0, 2'd0, 3'd3); tick();

        // Rejected writes: W^X and out-of-range index
        prog(3'd2, 32'h7000_0000, 32'h7000_FFFF, 3'b111, 1'b1, 1'b1, 1'b1); tick();
        fetch(32'h7000_0010, 1'b0, 2'd1, 3'd0); tick();
        prog(3'd6, 32'h8000_0000, 32'h8000_FFFF, 3'b001, 1'b1, 1'b0, 1'b1); tick();
        data(32'h8000_0000, 1'b0, 1'b0, 2'd1, 3'd0); tick();

        // Lock in the same cycle as a write, then write while locked
        prog(3'd0, 32'h9000_0000, 32'h9000_00FF, 3'b001, 1'b1, 1'b0, 1'b0); tick();
        lock_set = 1'b1;
        prog(3'd1, 32'hA000_0000, 32'hA000_00FF, 3'b001, 1'b1, 1'b0, 1'b1); tick();
        chk("locked_set", 32'(locked), 32'd1);
        data(32'hA000_0000, 1'b0, 1'b0, 2'd1, 3'd0); tick();
        prog(3'd0, 32'h9000_0000, 32'h9000_00FF, 3'b011, 1'b1, 1'b0, 1'b1); tick();
        data(32'h9000_0010, 1'b1, 1'b0, 2'd2, 3'd0); tick();
        data(32'h9000_0010, 1'b0, 1'b0, 2'd0, 3'd0); tick();
        chk("locked_sticky", 32'(locked), 32'd1);

        // Reset clears lock and table
        do_reset();
        fetch(32'h0000_0100, 1'b0, 2'd1, 3'd0);
        data(32'h9000_0010, 1'b0, 1'b0, 2'd1, 3'd0); tick();

        // Lock pulse alone, then write to idx1
        lock_set = 1'b1; tick();
        chk("locked_pulse", 32'(locked), 32'd1);
        prog(3'd1, 32'hB000_0000, 32'hB000_00FF, 3'b001, 1'b1, 1'b0, 1'b1); tick();
        data(32'hB000_0000, 1'b0, 1'b0, 2'd1, 3'd0); tick();

        repeat (3) tick();
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("d_q_drained", 32'(d_q.size()), 32'd0);
        chk("prog_q_drained", 32'(prog_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
